// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_t    - 3-bit opcode (ADD, SUB, SHL, SHR, AND, OR, XOR, EQ)
//   alu_flags_t - zero/carry/overflow flags that travel with each result
// Optional feature macro used by the design: ALU_PIPE_SAT_EN (saturating ADD/SUB).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQ  = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Parameters: WIDTH (operand width, 4..64), SHAMT (fixed shift distance, 1..WIDTH-1).
// Ports:
//   a, b   in  WIDTH  operands
//   op     in  3      alu_op_t opcode
//   result out WIDTH  result, truncated to WIDTH
//   flags  out 3      zero (result==0), carry (ADD carry / SUB borrow), ovf (signed overflow)
// Macro ALU_PIPE_SAT_EN: when defined, ADD/SUB results that overflow are clamped
// to the most positive / most negative signed value; flags are unaffected except
// zero, which always reflects the final result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHAMT = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic             carry;
    logic             ovf;

    // One extra bit on top holds the unsigned carry out (ADD) or borrow (SUB).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                raw   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                // Same-sign operands producing an opposite-sign result.
                ovf   = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
            end
            OP_SUB: begin
                raw   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                // Different-sign operands where the result sign differs from a.
                ovf   = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
            end
            OP_SHL:  raw = b << SHAMT;
            OP_SHR:  raw = b >> SHAMT;
            OP_AND:  raw = a & b;
            OP_OR:   raw = a | b;
            OP_XOR:  raw = a ^ b;
            OP_EQ:   raw = {{(WIDTH-1){1'b0}}, (a == b)};
            default: raw = '0;
        endcase
    end

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ovf is only ever set for ADD/SUB. In both cases the direction of the
    // overflow follows the sign of a: a non-negative a can only overflow upward.
    assign result = ovf ? (a[MSB] ? MIN_NEG : MAX_POS) : raw;
`else
    assign result = raw;
`endif

    assign flags.zero  = (result == '0);
    assign flags.carry = carry;
    assign flags.ovf   = ovf;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Parameters: WIDTH (4..64), SHAMT (1..WIDTH-1).
// Ports:
//   clk          in   1      clock, rising edge
//   reset_n      in   1      asynchronous active-low reset
//   in_valid_i   in   1      operand beat offered
//   in_ready_o   out  1      operand beat accepted this cycle
//   a_i, b_i     in   WIDTH  operands
//   op_i         in   3      alu_op_t opcode
//   out_valid_o  out  1      result beat presented
//   out_ready_i  in   1      consumer accepts result
//   alu_o        out  WIDTH  result
//   zero_o, carry_o, ovf_o out 1  flags belonging to the presented result
// Macro ALU_PIPE_SAT_EN (consumed by alu_core): saturating ADD/SUB. Port list is
// identical with or without it.
//
// Handshake: a beat moves across an interface only on a rising edge where valid
// and ready are both high; data/opcode are don't-care otherwise. A producer keeps
// valid and its data steady until that edge. in_ready_o depends on out_ready_i
// and stage occupancy only, never on in_valid_i.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHAMT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o
);

    // Stage 1: registered operands.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_t          s1_op;

    // Stage 2: registered result and its flags.
    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    alu_flags_t       s2_flags;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] core_res;
    alu_flags_t       core_flags;

    // S2 may load when empty or when its beat is leaving this cycle; S1 may
    // load when empty or when its beat moves into S2. This chaining lets a full
    // pipe accept and drain in the same cycle without a bubble.
    assign s2_adv     = !s2_valid || out_ready_i;
    assign s1_adv     = !s1_valid || s2_adv;
    assign in_ready_o = s1_adv;

    alu_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_res),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_a  <= a_i;
                s1_b  <= b_i;
                s1_op <= op_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            // Result and flags are captured together so they always describe
            // the same beat.
            if (s1_valid) begin
                s2_res   <= core_res;
                s2_flags <= core_flags;
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign alu_o       = s2_res;
    assign zero_o      = s2_flags.zero;
    assign carry_o     = s2_flags.carry;
    assign ovf_o       = s2_flags.ovf;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..64.
REQ-002 Parameter SHAMT, default 2, fixed shift distance for SHL/SHR; legal range 1..WIDTH-1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid_i  input  1  operand beat offered.
REQ-006 in_ready_o  output  1  block accepts beat this cycle.
REQ-007 a_i  input  WIDTH  operand A.
REQ-008 b_i  input  WIDTH  operand B.
REQ-009 op_i  input  3  opcode, alu_op_t.
REQ-010 out_valid_o  output  1  result beat presented.
REQ-011 out_ready_i  input  1  consumer accepts result.
REQ-012 alu_o  output  WIDTH  result.
REQ-013 zero_o  output  1  alu_o equals 0.
REQ-014 carry_o  output  1  unsigned carry (ADD) / borrow (SUB); 0 for other ops.
REQ-015 ovf_o  output  1  two's-complement overflow (ADD/SUB); 0 for other ops.

Function
REQ-016 Opcodes SHALL be: 0 ADD a+b, 1 SUB a-b, 2 SHL b<<SHAMT, 3 SHR b>>SHAMT (logical), 4 AND, 5 OR, 6 XOR, 7 EQ (alu_o=1 if a==b else 0); all results truncated to WIDTH.
REQ-017 Datapath SHALL be two register stages: S1 captures a/b/op on input handshake; S2 captures computed result and flags.
REQ-018 Handshake: transfer occurs only when valid and ready both high in the same cycle; input fields ignored otherwise.
REQ-019 S2 advances when !out_valid_o || out_ready_i; S1 advances when S1 empty or S2 advances; in_ready_o SHALL equal S1-advance condition (combinational from out_ready_i, not from in_valid_i).
REQ-020 Latency with out_ready_i held high: beat accepted in cycle N appears on out_valid_o in cycle N+2; throughput one beat per cycle.
REQ-021 While out_valid_o=1 and out_ready_i=0, alu_o and all flags SHALL stay stable; no beat lost, duplicated or reordered.
REQ-022 Simultaneous accept at input and drain at output with both stages full SHALL proceed without a bubble.
REQ-023 Flags SHALL be registered with alu_o and belong to the same beat.

Reset
REQ-024 reset_n low SHALL immediately clear S1/S2 valid bits; out_valid_o=0, alu_o=0, zero_o=0, carry_o=0, ovf_o=0.
REQ-025 in_ready_o SHALL be 1 during and after reset; in-flight beats at reset assertion are discarded.
REQ-026 Release of reset_n SHALL be synchronised externally; block needs no idle cycles after release.

Configuration
REQ-027 Macro ALU_PIPE_SAT_EN: when defined, ADD/SUB with signed overflow SHALL clamp alu_o to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); ovf_o still 1, carry_o unaffected by clamping.
REQ-028 Without ALU_PIPE_SAT_EN, ADD/SUB SHALL wrap modulo 2^WIDTH; port list identical in both builds.

Structure
REQ-029 Package alu_pkg SHALL hold alu_op_t (3-bit enum, values per REQ-016) and the flag struct type.
REQ-030 Combinational datapath SHALL be sub-module alu_core (WIDTH, SHAMT parameters; result + flags out); alu_pipe holds only stage registers and handshake.

Verification (WIDTH=8, SHAMT=2)
REQ-031 ADD a=0x7F b=0x01, ready high -> 2 cycles later alu_o=0x80, ovf=1, carry=0; with SAT_EN alu_o=0x7F.
REQ-032 SUB a=0x00 b=0x01 -> alu_o=0xFF, carry=1, ovf=0, zero=0; EQ a=b=0x5A -> alu_o=0x01.
REQ-033 SHL b=0xC3 -> 0x0C; SHR b=0xC3 -> 0x30; XOR a=b=0xAA -> 0x00, zero=1.
REQ-034 Stream 8 back-to-back beats, out_ready_i low for cycles 3-6 -> in_ready_o drops once both stages full, all 8 results emerge in order, output stable while stalled.
REQ-035 Assert reset_n low with two beats in flight -> out_valid_o=0 and alu_o=0 same cycle, in_ready_o=1; after release, next beat completes with 2-cycle latency.
